// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle sequencer for the 16-bit CPU datapath. Each instruction walks
//   FETCH -> DECODE -> EXEC -> WB. FETCH waits on the instruction-memory
//   handshake, and the machine stops for good on HALT_OP.
//
// Ports
//   clock        in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   start        in   level; leaves IDLE when high
//   op           in   IR[15:12], valid in DECODE
//   imem_ready   in   instruction present on the imem bus
//   imem_req     out  fetch request (FETCH)
//   ir_write     out  load IR (FETCH and imem_ready)
//   pc_write     out  PC <= PC+2 (FETCH and imem_ready)
//   reg_write    out  register-file write enable (WB)
//   reg_dst      out  1: WR=IR[7:6], 0: WR=IR[9:8]
//   alu_src      out  1: B=sext(IR[7:0]), 0: B=RD2
//   alu_control  out  ALU operation select
//   busy         out  state is neither IDLE nor HALT
//   halted       out  state is HALT
//   illegal      out  pulse in DECODE for an opcode in 1000..1110
//   cycle_count  out  busy cycles, saturating        (PERF_CNT_EN only)
//   instr_count  out  retired instructions, saturating (PERF_CNT_EN only)
//
// Build option: define PERF_CNT_EN to add the two performance counters.
module multicycle_ctrl #(
  parameter int              OP_W    = 4,
  parameter int              ALUC_W  = 4,
  parameter int              CNT_W   = 16,
  parameter logic [OP_W-1:0] HALT_OP = 4'b1111
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic              imem_ready,
  output logic              imem_req,
  output logic              ir_write,
  output logic              pc_write,
  output logic              reg_write,
  output logic              reg_dst,
  output logic              alu_src,
  output logic [ALUC_W-1:0] alu_control,
  output logic              busy,
  output logic              halted,
  output logic              illegal
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instr_count
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam int DEC_W = ALUC_W + 2;

  state_t          state, state_n;
  logic [OP_W-1:0] op_q, op_q_n;

  // {alu_control, reg_dst, alu_src} for each supported opcode
  function automatic logic [DEC_W-1:0] decode_op(input logic [OP_W-1:0] opc);
    logic [DEC_W-1:0] d;
    case (opc)
      OP_W'(0): d = {ALUC_W'(4'b0010), 1'b1, 1'b0};  // add
      OP_W'(1): d = {ALUC_W'(4'b0110), 1'b1, 1'b0};  // sub
      OP_W'(2): d = {ALUC_W'(4'b0000), 1'b1, 1'b0};  // and
      OP_W'(3): d = {ALUC_W'(4'b0001), 1'b1, 1'b0};  // or
      OP_W'(4): d = {ALUC_W'(4'b1100), 1'b1, 1'b0};  // nor
      OP_W'(5): d = {ALUC_W'(4'b1101), 1'b1, 1'b0};  // nand
      OP_W'(6): d = {ALUC_W'(4'b0111), 1'b1, 1'b0};  // slt
      OP_W'(7): d = {ALUC_W'(4'b0010), 1'b0, 1'b1};  // addi
      default:  d = '0;
    endcase
    return d;
  endfunction

  // Upper half of the opcode space, minus HALT_OP, is unsupported.
  function automatic logic is_illegal(input logic [OP_W-1:0] opc);
    return opc[OP_W-1] && (opc != HALT_OP);
  endfunction

  always_comb begin
    state_n = state;
    op_q_n  = op_q;
    case (state)
      IDLE:    if (start) state_n = FETCH;
      FETCH:   if (imem_ready) state_n = DECODE;
      DECODE: begin
        op_q_n = op;
        if (op == HALT_OP)   state_n = HALT;
        else if (is_illegal(op)) state_n = FETCH;
        else                 state_n = EXEC;
      end
      EXEC:    state_n = WB;
      WB:      state_n = FETCH;
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      op_q        <= '0;
      imem_req    <= 1'b0;
      reg_write   <= 1'b0;
      reg_dst     <= 1'b0;
      alu_src     <= 1'b0;
      alu_control <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state     <= state_n;
      op_q      <= op_q_n;
      imem_req  <= (state_n == FETCH);
      reg_write <= (state_n == WB);
      if (state_n == EXEC || state_n == WB)
        {alu_control, reg_dst, alu_src} <= decode_op(op_q_n);
      else
        {alu_control, reg_dst, alu_src} <= '0;
      busy      <= (state_n == FETCH) || (state_n == DECODE) ||
                   (state_n == EXEC)  || (state_n == WB);
      halted    <= (state_n == HALT);
    end
  end

  // The IR/PC strobes follow imem_ready in the same cycle; illegal follows op,
  // which is only valid while in DECODE.
  assign ir_write = (state == FETCH) && imem_ready;
  assign pc_write = (state == FETCH) && imem_ready;
  assign illegal  = (state == DECODE) && is_illegal(op);

`ifdef PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (state == FETCH || state == DECODE || state == EXEC || state == WB)
        cycle_count <= sat_inc(cycle_count);
      // Only instructions that reach WB retire; illegal and HALT never do.
      if (state == WB)
        instr_count <= sat_inc(instr_count);
    end
  end
`else
  // CNT_W only sizes the perf counters; keep it referenced in this build.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule
